// File: rtl/serial_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : serial_tx_arbiter
// Purpose  : Round-robin share of one MSB-first serializer between two
//            req/ack requesters, followed by a fixed inter-frame gap.
// Revision : 1.0 - initial release
// ============================================================================
module serial_tx_arbiter #(
   parameter int WIDTH = 8,
   parameter int GAP   = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             reqA,
   input  logic [WIDTH-1:0] dataA,
   output logic             ackA,
   input  logic             reqB,
   input  logic [WIDTH-1:0] dataB,
   output logic             ackB,
   output logic             serialOut,
   output logic             frameValid,
   output logic             frameSrc,
   output logic             done,
   output logic             busy
);

   localparam int c_cnt_w = $clog2(WIDTH);
   localparam int c_gap_w = (GAP > 0) ? $clog2(GAP + 1) : 1;
   localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(WIDTH - 1);
   localparam logic [c_cnt_w-1:0] c_pre_last = c_cnt_w'(WIDTH - 2);
   localparam logic [c_gap_w-1:0] c_gap_last = (GAP > 0) ? c_gap_w'(GAP - 1) : '0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t               r_state, w_state;
   logic [WIDTH-1:0]     r_sreg, w_sreg;
   logic [c_cnt_w-1:0]   r_bit_cnt, w_bit_cnt;
   logic [c_gap_w-1:0]   r_gap_cnt, w_gap_cnt;
   logic                 r_last_src, w_last_src;
   logic                 r_frame_src, w_frame_src;
   logic                 r_serial, w_serial;
   logic                 r_valid, w_valid;
   logic                 r_done, w_done;
   logic                 r_busy, w_busy;
   logic                 r_ack_a, w_ack_a;
   logic                 r_ack_b, w_ack_b;
   logic                 w_grant_b;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_sreg      <= '0;
         r_bit_cnt   <= '0;
         r_gap_cnt   <= '0;
         r_last_src  <= 1'b1;
         r_frame_src <= 1'b0;
         r_serial    <= 1'b0;
         r_valid     <= 1'b0;
         r_done      <= 1'b0;
         r_busy      <= 1'b0;
         r_ack_a     <= 1'b0;
         r_ack_b     <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_sreg      <= w_sreg;
         r_bit_cnt   <= w_bit_cnt;
         r_gap_cnt   <= w_gap_cnt;
         r_last_src  <= w_last_src;
         r_frame_src <= w_frame_src;
         r_serial    <= w_serial;
         r_valid     <= w_valid;
         r_done      <= w_done;
         r_busy      <= w_busy;
         r_ack_a     <= w_ack_a;
         r_ack_b     <= w_ack_b;
      end
   end

   always_comb begin
      w_state     = r_state;
      w_sreg      = r_sreg;
      w_bit_cnt   = r_bit_cnt;
      w_gap_cnt   = r_gap_cnt;
      w_last_src  = r_last_src;
      w_frame_src = r_frame_src;
      w_serial    = 1'b0;
      w_valid     = 1'b0;
      w_done      = 1'b0;
      w_ack_a     = 1'b0;
      w_ack_b     = 1'b0;
      // On a tie the requester that did not win last time gets the link
      w_grant_b   = reqB & ~(reqA & r_last_src);

      case (r_state)
         S_IDLE: begin
            if (reqA | reqB) begin
               w_state     = S_SHIFT;
               w_sreg      = w_grant_b ? dataB : dataA;
               w_serial    = w_sreg[WIDTH-1];
               w_valid     = 1'b1;
               w_frame_src = w_grant_b;
               w_last_src  = w_grant_b;
               w_ack_a     = ~w_grant_b;
               w_ack_b     = w_grant_b;
               w_bit_cnt   = '0;
            end
         end
         S_SHIFT: begin
            w_sreg = {r_sreg[WIDTH-2:0], 1'b0};
            if (r_bit_cnt == c_last_bit) begin
               w_state   = (GAP > 0) ? S_GAP : S_IDLE;
               w_gap_cnt = '0;
            end else begin
               w_bit_cnt = r_bit_cnt + 1'b1;
               w_serial  = r_sreg[WIDTH-2];
               w_valid   = 1'b1;
               w_done    = (r_bit_cnt == c_pre_last);
            end
         end
         S_GAP: begin
            if (r_gap_cnt == c_gap_last) begin
               w_state = S_IDLE;
            end else begin
               w_gap_cnt = r_gap_cnt + 1'b1;
            end
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase

      w_busy = (w_state != S_IDLE);
   end

   assign ackA       = r_ack_a;
   assign ackB       = r_ack_b;
   assign serialOut  = r_serial;
   assign frameValid = r_valid;
   assign frameSrc   = r_frame_src;
   assign done       = r_done;
   assign busy       = r_busy;

endmodule
`default_nettype wire

// File: doc/serial_tx_arbiter.md
# serial_tx_arbiter

Sequences and shares one 8-bit parallel-load, MSB-first serializer between two requesters (A and B). Each requester presents a parallel word under a req/ack handshake. The block arbitrates round-robin, parallel-loads the winner's word, and shifts it out one bit per clock with frame qualifiers. It then enforces an inter-frame gap before accepting the next request. It sits between byte-producing logic and a single serial link in the shift-register datapath.

## Interface
- WIDTH, 8: word width in bits; legal range WIDTH >= 2
- GAP, 1: extra idle cycles appended after each frame; legal range GAP >= 0
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- reqA  input  1  requester A has a word pending; held until ackA is seen
- dataA  input  WIDTH  A's word; stable while reqA is high
- ackA  output  1  one-cycle pulse: A's word captured
- reqB, dataB, ackB: same as above, for requester B
- serialOut  output  1  current serial bit; 0 when no frame is active
- frameValid  output  1  high during each of the WIDTH bit cycles
- frameSrc  output  1  source of the current or last frame; 0 = A, 1 = B
- done  output  1  high during the final bit cycle of a frame
- busy  output  1  high whenever state is not IDLE

## Operation
- Clock and reset: one clock (clk). Reset is synchronous and active-low.
- States: IDLE, SHIFT, GAP.
- Reset (reset=0 at an edge) sets:
  - state to IDLE
  - all outputs to 0
  - shift register to 0 and bit counter to 0
  - lastSrc to 1, so A wins the first tie
  - any in-flight frame is discarded; no ack or done is issued.
- IDLE:
  - Requests are sampled only at edges where state == IDLE.
  - Neither request high: stay in IDLE.
  - One request high: grant that requester.
  - Both high: grant the requester not equal to lastSrc.
- At the grant edge:
  - shift register <= granted data
  - serialOut <= data[WIDTH-1]
  - frameValid <= 1
  - frameSrc <= granted source; lastSrc <= granted source
  - the granted requester's ack <= 1 for exactly one cycle
  - bit counter <= 0; state <= SHIFT.
- SHIFT:
  - At each edge, shift left by one with zero fill, increment the counter, and set serialOut to the new MSB.
  - Requests are ignored.
  - done = 1 in the cycle where counter == WIDTH-1 (the last bit).
  - At the edge ending that cycle: frameValid, serialOut and done go to 0.
  - Next state is GAP if GAP > 0, otherwise IDLE.
- GAP:
  - Counts GAP cycles, then goes to IDLE.
  - Outputs are 0; requests are ignored.
- Holding outputs: frameSrc keeps its last value outside frames. busy = (state != IDLE), registered.
- Widths: bit counter is $clog2(WIDTH) bits and the gap counter is $clog2(GAP+1) bits; neither wraps past its terminal count.
- Handshake rules:
  - A requester that keeps req high after seeing ack is treated as a new request at the next IDLE edge.
  - Requester data is never sampled outside the grant edge.

## Timing
- Grant-edge latency: ack and bit WIDTH-1 appear in the same cycle, the first cycle after the grant edge.
- Bit k (MSB first, k = 0..WIDTH-1) is on serialOut in cycle k+1 after the grant edge.
- done is in cycle WIDTH.
- frameValid is low for exactly 1+GAP cycles between consecutive frames: GAP cycles in GAP plus one IDLE cycle.
- Back-to-back throughput: one frame per WIDTH+1+GAP cycles.
- Simultaneous events:
  - A req rising during SHIFT or GAP waits and is served at the first IDLE edge.
  - If reset=0 and req=1 at the same edge, reset wins.
- Reset released: the first edge with reset=1 is an IDLE edge and can grant, so ack can appear in the second cycle after release.

## Test plan
- Hold reset=0 for 3 cycles with reqA=1, dataA=0xFF:
  - All outputs stay 0.
  - After release, ackA=1 in the second cycle, with serialOut=1 and frameValid=1.
- Only reqA, dataA=0xA5:
  - ackA is a single-cycle pulse.
  - serialOut = 1,0,1,0,0,1,0,1 over 8 consecutive frameValid cycles, frameSrc=0.
  - done only on the 8th bit; frameValid=0 for 2 cycles afterwards (GAP=1).
- reqA (0x0F) and reqB (0xF0) asserted in the same cycle from IDLE, each dropping req after its ack:
  - A's frame first (00001111, frameSrc=0).
  - Then, after 2 idle cycles, B's frame (11110000, frameSrc=1).
- reqA and reqB held high continuously for 4 frames:
  - frameSrc sequence is 0,1,0,1.
  - ackA and ackB alternate; exactly 4 ack pulses in total.
- Reset driven low during bit 4 of an A frame (dataA=0xC3):
  - Next cycle: serialOut=0, frameValid=0, busy=0; no done.
  - reqA still high: frame restarts from bit 0 after release, with a new ackA.
- Instance with WIDTH=8, GAP=3, both requesters saturated:
  - frameValid low for exactly 4 cycles between frames.
  - Frame period is 12 cycles.
